// File: rtl/alu_seq_ctrl.sv
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Sequential command front-end for an external combinational
//               16-bit ALU. It holds a 4-entry x 16-bit register file and
//               accepts load/operate commands over a valid/ready channel. It
//               drives registered operands, carry and opcode to the ALU, then
//               writes the result back and returns it, with its flags, over a
//               valid/ready response channel.
// Ports       : clk, rst_n             - clock, async active-low reset
//               cmd_valid/cmd_ready    - command handshake
//               cmd_load, cmd_op, cmd_cin, cmd_dst, cmd_src1, cmd_src2,
//               cmd_imm                - command fields
//               alu_a, alu_b, alu_c, alu_opc - registered ALU inputs
//               alu_w, alu_zer, alu_neg      - ALU result and flags
//               rsp_valid/rsp_ready    - response handshake
//               rsp_data, rsp_zer, rsp_neg   - response payload
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_ctrl #(
  parameter int RF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_load,
  input  logic [2:0]  cmd_op,
  input  logic        cmd_cin,
  input  logic [1:0]  cmd_dst,
  input  logic [1:0]  cmd_src1,
  input  logic [1:0]  cmd_src2,
  input  logic [15:0] cmd_imm,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_c,
  output logic [2:0]  alu_opc,
  input  logic [15:0] alu_w,
  input  logic        alu_zer,
  input  logic        alu_neg,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_zer,
  output logic        rsp_neg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;

  logic [15:0] rf_q [RF_DEPTH];
  logic [15:0] alu_a_q;
  logic [15:0] alu_b_q;
  logic        alu_c_q;
  logic [2:0]  alu_opc_q;
  logic [1:0]  dst_q;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_zer_q,  rsp_zer_d;
  logic        rsp_neg_q,  rsp_neg_d;

  logic        accept_op;
  logic        accept_ld;
  logic        wr_en;
  logic [1:0]  wr_addr;

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    accept_op  = 1'b0;
    accept_ld  = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = dst_q;
    rsp_data_d = rsp_data_q;
    rsp_zer_d  = rsp_zer_q;
    rsp_neg_d  = rsp_neg_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_load) begin
            // Loads bypass the ALU: write and respond directly from the immediate.
            accept_ld  = 1'b1;
            wr_en      = 1'b1;
            wr_addr    = cmd_dst;
            rsp_data_d = cmd_imm;
            rsp_zer_d  = (cmd_imm == 16'h0000);
            rsp_neg_d  = cmd_imm[15];
            state_d    = RESP;
          end else begin
            accept_op  = 1'b1;
            state_d    = EXEC;
          end
        end
      end
      EXEC: begin
        // ALU has had a full cycle to settle on the registered operands.
        wr_en      = 1'b1;
        wr_addr    = dst_q;
        rsp_data_d = alu_w;
        rsp_zer_d  = alu_zer;
        rsp_neg_d  = alu_neg;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // ALU input registers: loaded only on an accepted operate command, so they
  // hold their values across loads and idle periods.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q   <= 16'h0000;
      alu_b_q   <= 16'h0000;
      alu_c_q   <= 1'b0;
      alu_opc_q <= 3'd0;
      dst_q     <= 2'd0;
    end else if (accept_op) begin
      // Operands are read before any write-back, so src==dst sees the old value.
      alu_a_q   <= rf_q[cmd_src1];
      alu_b_q   <= rf_q[cmd_src2];
      alu_c_q   <= cmd_cin;
      alu_opc_q <= cmd_op;
      dst_q     <= cmd_dst;
    end
  end

  // --------------------------------------------------------------------------
  // Register file and response payload
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= 16'h0000;
      end
      rsp_data_q <= 16'h0000;
      rsp_zer_q  <= 1'b0;
      rsp_neg_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        rf_q[wr_addr] <= rsp_data_d;
      end
      rsp_data_q <= rsp_data_d;
      rsp_zer_q  <= rsp_zer_d;
      rsp_neg_q  <= rsp_neg_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: handshake signals depend on state only.
  // --------------------------------------------------------------------------
  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_c     = alu_c_q;
  assign alu_opc   = alu_opc_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zer   = rsp_zer_q;
  assign rsp_neg   = rsp_neg_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Directed self-checking bench for alu_seq_ctrl, with a
//               behavioural model of the team's 16-bit ALU in the loop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_load;
  logic [2:0]  cmd_op;
  logic        cmd_cin;
  logic [1:0]  cmd_dst;
  logic [1:0]  cmd_src1;
  logic [1:0]  cmd_src2;
  logic [15:0] cmd_imm;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_c;
  logic [2:0]  alu_opc;
  logic [15:0] alu_w;
  logic        alu_zer;
  logic        alu_neg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_zer;
  logic        rsp_neg;

  int checks;
  int errors;

  alu_seq_ctrl #(.RF_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_op    (cmd_op),
    .cmd_cin   (cmd_cin),
    .cmd_dst   (cmd_dst),
    .cmd_src1  (cmd_src1),
    .cmd_src2  (cmd_src2),
    .cmd_imm   (cmd_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c),
    .alu_opc   (alu_opc),
    .alu_w     (alu_w),
    .alu_zer   (alu_zer),
    .alu_neg   (alu_neg),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zer   (rsp_zer),
    .rsp_neg   (rsp_neg)
  );

  // Team ALU behaviour: 0 negate, 1 increment, 2 add with carry,
  // 3 A + (B >>> 1), 4 and, 5 or, 6 {A[7:0],B[7:0]}, 7 zero.
  always_comb begin
    alu_w = 16'h0000;
    case (alu_opc)
      3'd0: alu_w = 16'h0000 - alu_a;
      3'd1: alu_w = alu_a + 16'h0001;
      3'd2: alu_w = alu_a + alu_b + {15'h0000, alu_c};
      3'd3: alu_w = alu_a + {alu_b[15], alu_b[15:1]};
      3'd4: alu_w = alu_a & alu_b;
      3'd5: alu_w = alu_a | alu_b;
      3'd6: alu_w = {alu_a[7:0], alu_b[7:0]};
      default: alu_w = 16'h0000;
    endcase
    alu_zer = (alu_w == 16'h0000);
    alu_neg = alu_w[15];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load command with rsp_ready already high; response one cycle after accept.
  task automatic do_load(input string tag, input logic [1:0] dst, input logic [15:0] imm,
                         input logic ezer, input logic eneg);
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_dst = dst; cmd_imm = imm;
    step();
    cmd_valid = 1'b0;
    chk({tag, ".rsp_valid"}, rsp_valid, 1);
    chk({tag, ".rsp_data"},  rsp_data,  imm);
    chk({tag, ".rsp_zer"},   rsp_zer,   ezer);
    chk({tag, ".rsp_neg"},   rsp_neg,   eneg);
    step();
    chk({tag, ".idle"}, cmd_ready, 1);
  endtask

  // Operate command; response two cycles after accept.
  task automatic do_op(input string tag, input logic [2:0] op, input logic cin,
                       input logic [1:0] dst, input logic [1:0] s1, input logic [1:0] s2,
                       input logic [15:0] ea, input logic [15:0] eb,
                       input logic [15:0] ew, input logic ezer, input logic eneg);
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = op; cmd_cin = cin;
    cmd_dst = dst; cmd_src1 = s1; cmd_src2 = s2;
    step();
    cmd_valid = 1'b0;
    chk({tag, ".exec_rsp_valid"}, rsp_valid, 0);
    chk({tag, ".alu_a"},   alu_a,   ea);
    chk({tag, ".alu_b"},   alu_b,   eb);
    chk({tag, ".alu_c"},   alu_c,   cin);
    chk({tag, ".alu_opc"}, alu_opc, op);
    step();
    chk({tag, ".rsp_valid"}, rsp_valid, 1);
    chk({tag, ".rsp_data"},  rsp_data,  ew);
    chk({tag, ".rsp_zer"},   rsp_zer,   ezer);
    chk({tag, ".rsp_neg"},   rsp_neg,   eneg);
    step();
    chk({tag, ".idle"}, cmd_ready, 1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_op    = 3'd0;
    cmd_cin   = 1'b0;
    cmd_dst   = 2'd0;
    cmd_src1  = 2'd0;
    cmd_src2  = 2'd0;
    cmd_imm   = 16'h0000;
    rsp_ready = 1'b1;

    // Reset state
    #2;
    chk("rst.cmd_ready", cmd_ready, 1);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_data",  rsp_data,  16'h0000);
    chk("rst.alu_a",     alu_a,     16'h0000);
    chk("rst.alu_b",     alu_b,     16'h0000);
    chk("rst.alu_opc",   alu_opc,   3'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Loads
    do_load("ld_r1", 2'd1, 16'h0005, 1'b0, 1'b0);
    do_load("ld_r2", 2'd2, 16'hFFFE, 1'b0, 1'b1);

    // Add with carry: 5 + 0xFFFE + 1 = 0x0004
    do_op("add", 3'd2, 1'b1, 2'd3, 2'd1, 2'd2, 16'h0005, 16'hFFFE, 16'h0004, 1'b0, 1'b0);
    // Opcode 7 forwarded; also reads R3 back to confirm the write
    do_op("op7", 3'd7, 1'b0, 2'd2, 2'd3, 2'd3, 16'h0004, 16'h0004, 16'h0000, 1'b1, 1'b0);

    // Negate zero, then increment in place
    do_load("ld_r0", 2'd0, 16'h0000, 1'b1, 1'b0);
    do_op("neg0", 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    do_op("inc0", 3'd1, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0);

    // Back-pressure: load R1 with rsp_ready low, second command waiting
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_load = 1'b1; cmd_dst = 2'd1; cmd_imm = 16'h1234;
    step();
    cmd_dst = 2'd2; cmd_imm = 16'h8002;
    for (int i = 0; i < 5; i++) begin
      chk("bp.rsp_valid", rsp_valid, 1);
      chk("bp.rsp_data",  rsp_data,  16'h1234);
      chk("bp.cmd_ready", cmd_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    chk("bp.last_data", rsp_data, 16'h1234);
    step();
    chk("bp.idle_ready", cmd_ready, 1);
    chk("bp.idle_valid", rsp_valid, 0);
    step();
    cmd_valid = 1'b0;
    chk("bp.second_valid", rsp_valid, 1);
    chk("bp.second_data",  rsp_data,  16'h8002);
    chk("bp.second_neg",   rsp_neg,   1);
    step();

    // Shift-add and concat
    do_op("shadd",  3'd3, 1'b0, 2'd3, 2'd1, 2'd2, 16'h1234, 16'h8002, 16'hD235, 1'b0, 1'b1);
    do_op("concat", 3'd6, 1'b0, 2'd3, 2'd1, 2'd2, 16'h1234, 16'h8002, 16'h3402, 1'b0, 1'b0);

    // Mid-operation reset during EXEC
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd2; cmd_cin = 1'b1;
    cmd_dst = 2'd3; cmd_src1 = 2'd1; cmd_src2 = 2'd2;
    step();
    cmd_valid = 1'b0;
    chk("mr.in_exec", rsp_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("mr.alu_a",     alu_a,     16'h0000);
    chk("mr.alu_opc",   alu_opc,   3'd0);
    chk("mr.alu_c",     alu_c,     0);
    chk("mr.rsp_data",  rsp_data,  16'h0000);
    chk("mr.rsp_neg",   rsp_neg,   0);
    chk("mr.rsp_valid", rsp_valid, 0);
    chk("mr.cmd_ready", cmd_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    chk("mr.post_ready", cmd_ready, 1);
    chk("mr.post_valid", rsp_valid, 0);
    do_op("mr.r3", 3'd7, 1'b0, 2'd0, 2'd3, 2'd1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
